// File: rtl/e603_gnrl_cdc_tx_ctrl_pkg.sv
// Shared definitions for the 4-phase req/ack CDC controllers (tx and rx sides).
package e603_gnrl_cdc_tx_ctrl_pkg;

  typedef enum logic [1:0] {
    CDC_IDLE = 2'd0,
    CDC_REQ  = 2'd1,
    CDC_REL  = 2'd2
  } cdc_state_e;

  localparam int CDC_SYNC_DP = 2;
  localparam int CDC_DW_DEF  = 32;

  // Acknowledge while no transfer is outstanding breaks the handshake.
  function automatic logic cdc_ack_violation(input cdc_state_e st, input logic ack);
    return (st == CDC_IDLE) & ack;
  endfunction

endpackage

// File: rtl/e603_gnrl_cdc_tx_ctrl_lib.sv
// Generic flop primitives: reset synchronizer chain, reset flop, load-enable reset flop.
module e603_gnrl_tech_sync #(
  parameter int            DW      = 1,
  parameter int            DP      = 2,
  parameter logic [DW-1:0] RST_VAL = {DW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din_a,
  output logic [DW-1:0] dout
);

  logic [DP-1:0][DW-1:0] sync_r;

  // Shift the asynchronous input through DP flop stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {DP{RST_VAL}};
    end else begin
      sync_r <= {sync_r[DP-2:0], din_a};
    end
  end

  assign dout = sync_r[DP-1];

endmodule

module e603_gnrl_dffr #(
  parameter int            DW      = 1,
  parameter logic [DW-1:0] RST_VAL = {DW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  logic [DW-1:0] qout_r;

  // Plain register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qout_r <= RST_VAL;
    end else begin
      qout_r <= dnxt;
    end
  end

  assign qout = qout_r;

endmodule

module e603_gnrl_dfflr #(
  parameter int            DW      = 1,
  parameter logic [DW-1:0] RST_VAL = {DW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  logic [DW-1:0] qout_r;

  // Register that only updates when lden is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qout_r <= RST_VAL;
    end else if (lden) begin
      qout_r <= dnxt;
    end else begin
      qout_r <= qout_r;
    end
  end

  assign qout = qout_r;

endmodule

// File: rtl/e603_gnrl_cdc_tx_ctrl.sv
// Transmit side of a 4-phase req/ack crossing: accepts a local word, holds it on
// o_dat and walks o_req through rise / ack / fall / ack-release.
module e603_gnrl_cdc_tx_ctrl
  import e603_gnrl_cdc_tx_ctrl_pkg::*;
#(
  parameter int            DW      = CDC_DW_DEF,
  parameter int            DP      = CDC_SYNC_DP,
  parameter logic [DW-1:0] DAT_RST = {DW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_req,
  output logic [DW-1:0] o_dat,
  input  logic          ack_a,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);

  logic       ack_s;
  logic [1:0] state_q;
  cdc_state_e state_r;
  cdc_state_e state_nxt_s;
  logic       req_r;
  logic       done_r;
  logic       err_r;
  logic       req_nxt_s;
  logic       done_nxt_s;
  logic       err_nxt_s;
  logic       pay_ld_s;
  logic       rdy_s;

  e603_gnrl_tech_sync #(
    .DW     (1),
    .DP     (DP),
    .RST_VAL(1'b0)
  ) u_ack_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din_a(ack_a),
    .dout (ack_s)
  );

  assign state_r = cdc_state_e'(state_q);
  assign rdy_s   = (state_r == CDC_IDLE) & ~ack_s & ~err_r;

  // Next-state and next-output decode for the handshake FSM.
  always_comb begin
    state_nxt_s = state_r;
    req_nxt_s   = req_r;
    done_nxt_s  = 1'b0;
    err_nxt_s   = err_r | cdc_ack_violation(state_r, ack_s);
    pay_ld_s    = 1'b0;
    case (state_r)
      CDC_IDLE: begin
        if (i_vld & rdy_s) begin
          state_nxt_s = CDC_REQ;
          req_nxt_s   = 1'b1;
          pay_ld_s    = 1'b1;
        end else begin
          req_nxt_s   = 1'b0;
        end
      end
      CDC_REQ: begin
        if (ack_s) begin
          state_nxt_s = CDC_REL;
          req_nxt_s   = 1'b0;
        end else begin
          req_nxt_s   = 1'b1;
        end
      end
      CDC_REL: begin
        if (!ack_s) begin
          state_nxt_s = CDC_IDLE;
          done_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = CDC_REL;
        end
      end
      default: begin
        state_nxt_s = CDC_IDLE;
        req_nxt_s   = 1'b0;
      end
    endcase
  end

  e603_gnrl_dffr #(
    .DW     (2),
    .RST_VAL(2'b00)
  ) u_state_dff (
    .clk  (clk),
    .rst_n(rst_n),
    .dnxt (state_nxt_s),
    .qout (state_q)
  );

  // o_req comes straight from a flop so the remote side never sees a glitch.
  e603_gnrl_dffr #(
    .DW     (3),
    .RST_VAL(3'b000)
  ) u_flag_dff (
    .clk  (clk),
    .rst_n(rst_n),
    .dnxt ({req_nxt_s, done_nxt_s, err_nxt_s}),
    .qout ({req_r, done_r, err_r})
  );

  e603_gnrl_dfflr #(
    .DW     (DW),
    .RST_VAL(DAT_RST)
  ) u_pay_dff (
    .clk  (clk),
    .rst_n(rst_n),
    .lden (pay_ld_s),
    .dnxt (i_dat),
    .qout (o_dat)
  );

  assign i_rdy  = rdy_s;
  assign o_req  = req_r;
  assign o_done = done_r;
  assign o_err  = err_r;
  assign o_busy = (state_r != CDC_IDLE);

endmodule

// File: doc/e603_gnrl_cdc_tx_ctrl.md
Name: e603_gnrl_cdc_tx_ctrl

Overview:
Transmit-side controller for a 4-phase req/ack clock-domain-crossing handshake. Accepts words from a local valid/ready source and drives a level request plus a held-stable data bus toward an asynchronous receiver. Samples the receiver's asynchronous acknowledge through an internal synchronizer chain. Sits at the local-domain boundary of every bus or peripheral crossing in the core (debug, RTC, external-interrupt CDC paths).

Parameters:
DW, 32, payload width in bits
DP, 2, synchronizer depth for the acknowledge input (>=2)
DAT_RST, {DW{1'b0}}, reset value of the held payload register

Ports:
clk  input  1  local clock
rst_n  input  1  asynchronous active-low reset
i_vld  input  1  local source valid
i_rdy  output  1  local source ready
i_dat  input  DW  local payload
o_req  output  1  level request to the remote domain; registered, glitch-free
o_dat  output  DW  payload to the remote domain; held stable while the transfer is active
ack_a  input  1  asynchronous acknowledge from the remote domain
o_busy  output  1  transfer in progress (state != IDLE)
o_done  output  1  one-cycle pulse when a full 4-phase cycle completes
o_err  output  1  sticky flag: ack seen high while IDLE (protocol violation)

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Ack synchronization: ack_a passes through a DP-stage flop chain with reset value 0. Its output is ack_s. No combinational use of ack_a anywhere.
- State machine: 2-bit state with IDLE=0, REQ=1, REL=2.
- Ready: i_rdy = (state==IDLE) & ~ack_s & ~o_err.
- IDLE: on i_vld & i_rdy, latch i_dat into the payload register and move to REQ. o_req rises on the same edge.
- REQ: o_req=1. When ack_s==1 is sampled, move to REL; o_req falls on that edge.
- REL: o_req=0. When ack_s==0 is sampled, move to IDLE; o_done pulses high for the cycle following that edge.
- o_dat = payload register. It updates only on acceptance, so it is stable from o_req rise until IDLE is re-entered.
- Latency (DP=2): ack edge at the input -> state change DP+1 = 3 clk edges later. Minimum transfer is 1 accept edge + 2x(DP+1) edges.
- Throughput: at most one transfer in flight. i_rdy stays low in REQ and REL, and a new accept is possible in the cycle after o_done.
- o_busy = (state != IDLE).
- Boundary cases:
  - ack_s==1 while IDLE: i_rdy is forced low, o_err is set (sticky until reset), and the FSM stays in IDLE.
  - ack_s==0 while in REL: this is the normal exit to IDLE, not an error.
  - ack_s dropping while in REQ: ignored; the FSM keeps waiting for ack_s==1.
  - i_vld deasserting while i_rdy is low: legal, no effect.
- Reset (also mid-transfer): state=IDLE, o_req=0, o_dat=DAT_RST, sync chain=0, o_done=0, o_err=0, o_busy=0. The remote side is responsible for dropping ack after seeing o_req low.
- No arithmetic. All widths are exact and there are no counters to wrap.

Decomposition:
- Shared package: state encodings IDLE/REQ/REL, and the default DP constant shared with the rx-side controller.
- Sub-module: instantiate e603_gnrl_tech_sync with DW=1, DP=DP, RST_VAL=1'b0 for ack_a. The payload register and state register use e603_gnrl_dfflr / e603_gnrl_dffr.

Test Plan:
1. Basic transfer (DP=2): i_vld=1, i_dat=32'hA5A5_0001 at edge 0.
   -> i_rdy=1 at edge 0; o_req=1 and o_dat=32'hA5A5_0001 after edge 0.
   -> Bench raises ack_a before edge 5; o_req=0 after edge 7.
   -> Bench drops ack_a before edge 10; o_done=1 in the cycle after edge 12; i_rdy=1 again.
2. Data stability: change i_dat every cycle during REQ/REL -> o_dat constant at the accepted value; no second accept until after o_done.
3. Back-to-back: i_vld held high with 3 words (1, 2, 3) -> exactly 3 o_req pulses and 3 o_done pulses, in order, with o_dat matching each word.
4. Protocol error: ack_a=1 while IDLE -> after 2 edges i_rdy=0; o_err=1 and sticky; i_vld is not accepted; rst_n pulse clears o_err.
5. Reset mid-transfer: assert rst_n=0 while in REQ -> o_req=0, o_busy=0, o_dat=DAT_RST immediately (async). After release with ack_a=0, i_rdy=1 after 2 edges.
6. Ack glitch in REQ: ack_a high for 3 cycles, then low, then high -> REL entered on the first sampled high. A subsequent low returns the FSM to IDLE with exactly one o_done.
